acc_req_arbiter: RTL and testbench

// Shares one accelerator request/response bus between NumReq offloading cores (acc_adapter instances).
// - Request path (q): round-robin arbitration with grant lock.
// - Response path (p): writeback responses return to the originating core via an in-order route FIFO.
// - Sits between the adapters' acc_req_o/acc_rsp_i and the accelerator interconnect.
// - Accelerators behind this bus return writeback responses in issue order.

---
 rtl/acc_req_arbiter_pkg.sv | 36 +++
 rtl/acc_req_arbiter_if.sv | 18 +
 rtl/acc_req_arbiter_fifo.sv | 54 +++++
 rtl/acc_req_arbiter.sv | 105 ++++++++++
 tb/tb_acc_req_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_req_arbiter_pkg.sv
// rtl/acc_req_arbiter_pkg.sv - channel payload types and round-robin search helper
package acc_req_arbiter_pkg;

  localparam int unsigned MaxReqs = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data_arga;
    logic [31:0] data_argb;
    logic [31:0] data_argc;
    logic [31:0] data_op;
    logic [4:0]  id;
  } acc_req_chan_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
    logic        error;
  } acc_rsp_chan_t;

  // First set bit of valid_vec at or after ptr, wrapping at n; returns ptr when none is set.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [MaxReqs-1:0] valid_vec,
                                          input int unsigned n);
    int unsigned idx;
    rr_next = ptr;
    for (int unsigned k = MaxReqs; k > 0; k--) begin
      if (k <= n) begin
        idx = ptr + k - 1;
        if (idx >= n) idx = idx - n;
        if (valid_vec[idx[$clog2(MaxReqs)-1:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/acc_req_arbiter_if.sv
// rtl/acc_req_arbiter_if.sv - accelerator request/response bus bundle, N lanes wide
interface acc_req_arbiter_if #(
  parameter int unsigned N = 1
);
  import acc_req_arbiter_pkg::*;

  acc_req_chan_t [N-1:0] q;
  logic [N-1:0]          q_wb;
  logic [N-1:0]          q_valid;
  logic [N-1:0]          q_ready;
  acc_rsp_chan_t [N-1:0] p;
  logic [N-1:0]          p_valid;
  logic [N-1:0]          p_ready;

  modport master (output q, q_wb, q_valid, p_ready, input q_ready, p, p_valid);
  modport slave  (input q, q_wb, q_valid, p_ready, output q_ready, p, p_valid);

endinterface

// File: rtl/acc_req_arbiter_fifo.sv
// rtl/acc_req_arbiter_fifo.sv - non fall-through route FIFO of requester indices
module acc_req_arbiter_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);

endmodule

// File: rtl/acc_req_arbiter.sv
// rtl/acc_req_arbiter.sv - round-robin request arbiter with grant lock and in-order response routing
module acc_req_arbiter
  import acc_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  acc_req_arbiter_if.slave                    slv,
  acc_req_arbiter_if.master                   mst,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                orphan_rsp_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]        state_q;
  logic [IdxW-1:0]   rr_ptr_q, lock_idx_q, grant, head_idx;
  logic [NumReq-1:0] req_mask;
  logic              gnt_valid, q_hs, push, pop, rsp_route;
  logic              fifo_full, fifo_empty;

  // fifo_full is registered, so q readiness never depends on the p channel in the same cycle.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_mask[i] = slv.q_valid[i] & (~slv.q_wb[i] | ~fifo_full);
    end
  end

  always_comb begin
    if (state_q == StLocked) begin
      grant     = lock_idx_q;
      gnt_valid = slv.q_valid[lock_idx_q];
    end else begin
      grant     = IdxW'(rr_next(32'(rr_ptr_q), MaxReqs'(req_mask), NumReq));
      gnt_valid = |req_mask;
    end
  end

  assign mst.q[0]       = slv.q[grant];
  assign mst.q_wb[0]    = slv.q_wb[grant];
  assign mst.q_valid[0] = gnt_valid;
  assign q_hs           = gnt_valid & mst.q_ready[0];
  assign push           = q_hs & slv.q_wb[grant];

  always_comb begin
    slv.q_ready        = '0;
    slv.q_ready[grant] = q_hs;
  end

  assign rsp_route      = mst.p_valid[0] & ~fifo_empty;
  assign pop            = rsp_route & slv.p_ready[head_idx];
  // With an empty route FIFO the response has no owner and is accepted and dropped.
  assign mst.p_ready[0] = mst.p_valid[0] & (fifo_empty | slv.p_ready[head_idx]);

  always_comb begin
    slv.p_valid           = '0;
    slv.p_valid[head_idx] = rsp_route;
    for (int i = 0; i < NumReq; i++) begin
      slv.p[i] = mst.p[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      orphan_rsp_o <= 1'b0;
    end else begin
      if (q_hs) begin
        state_q  <= StIdle;
        rr_ptr_q <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + IdxW'(1);
      end else if (gnt_valid) begin
        state_q    <= StLocked;
        lock_idx_q <= grant;
      end
      if (mst.p_valid[0] & fifo_empty) orphan_rsp_o <= 1'b1;
    end
  end

  acc_req_arbiter_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (outstanding_o)
  );

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   mst.q_valid[0] && !mst.q_ready[0] |=> $stable(mst.q[0]));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(slv.q_ready));

endmodule

// File: tb/tb_acc_req_arbiter.sv
// tb/tb_acc_req_arbiter.sv - directed and randomized checks of acc_req_arbiter against a queue model
module tb_acc_req_arbiter;
  import acc_req_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int MO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       orphan;
  int         tests = 0;
  int         failed = 0;

  acc_req_chan_t core_req [NR];
  acc_rsp_chan_t rsp;

  acc_req_arbiter_if #(.N(NR)) slv ();
  acc_req_arbiter_if #(.N(1))  mst ();

  acc_req_arbiter #(.NumReq(NR), .MaxOutstanding(MO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slv           (slv),
    .mst           (mst),
    .outstanding_o (outstanding),
    .orphan_rsp_o  (orphan)
  );

  always #5 clk = ~clk;

  // Reference model state: round-robin pointer, lock, route queue, orphan flag.
  int m_ptr;
  bit m_locked;
  int m_lock;
  int rq[$];
  bit m_orphan;
  bit e_gv;
  int e_g;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv.q_valid = '0; slv.q_wb = '0; slv.q = '0; slv.p_ready = '0;
    mst.q_ready = '0; mst.p_valid = '0; mst.p = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic acc_req_chan_t mk_req(input int tag);
    acc_req_chan_t r;
    r.addr = $urandom; r.data_arga = $urandom; r.data_argb = $urandom;
    r.data_argc = $urandom; r.data_op = $urandom; r.id = 5'(tag);
    return r;
  endfunction

  function automatic acc_rsp_chan_t mk_rsp();
    acc_rsp_chan_t r;
    r.id = 5'($urandom); r.data = $urandom; r.error = 1'($urandom);
    return r;
  endfunction

  task automatic set_core(input int i, input bit valid, input bit wb, input int tag);
    core_req[i] = mk_req(tag);
    slv.q[i] = core_req[i];
    slv.q_valid[i] = valid;
    slv.q_wb[i] = wb;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (mst.q_valid[0] !== 1'b0) begin failed++; $display("FAIL reset_q_valid got %b want 0", mst.q_valid[0]); end
    tests++; if (slv.q_ready !== 2'b00) begin failed++; $display("FAIL reset_q_ready got %b want 00", slv.q_ready); end
    tests++; if (slv.p_valid !== 2'b00) begin failed++; $display("FAIL reset_p_valid got %b want 00", slv.p_valid); end
    tests++; if (mst.p_ready[0] !== 1'b0) begin failed++; $display("FAIL reset_p_ready got %b want 0", mst.p_ready[0]); end
    tests++; if (outstanding !== 3'd0) begin failed++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    tests++; if (orphan !== 1'b0) begin failed++; $display("FAIL reset_orphan got %b want 0", orphan); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mst.q_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_core(0, 1'b1, 1'b1, 2 * c);
      set_core(1, 1'b1, 1'b1, 2 * c + 1);
      @(negedge clk);
      tests++; if (slv.q_ready !== 2'(1 << (c % 2))) begin failed++; $display("FAIL rr_grant c%0d got %b want %b", c, slv.q_ready, 2'(1 << (c % 2))); end
      tests++; if (mst.q[0] !== core_req[c % 2]) begin failed++; $display("FAIL rr_payload c%0d got %h want %h", c, mst.q[0], core_req[c % 2]); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    tests++; if (outstanding !== 3'd4) begin failed++; $display("FAIL rr_outstanding got %0d want 4", outstanding); end
    tick();
    slv.p_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      rsp = mk_rsp(); mst.p[0] = rsp; mst.p_valid[0] = 1'b1;
      @(negedge clk);
      tests++; if (slv.p_valid !== 2'(1 << (c % 2))) begin failed++; $display("FAIL rr_route c%0d got %b want %b", c, slv.p_valid, 2'(1 << (c % 2))); end
      tests++; if (slv.p[c % 2] !== rsp) begin failed++; $display("FAIL rr_rsp_data c%0d got %h want %h", c, slv.p[c % 2], rsp); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    set_core(1, 1'b1, 1'b0, 11);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) set_core(0, 1'b1, 1'b0, 10);
      mst.q_ready[0] = (c >= 3);
      @(negedge clk);
      tests++; if (mst.q_valid[0] !== 1'b1) begin failed++; $display("FAIL lock_valid c%0d got %b want 1", c, mst.q_valid[0]); end
      tests++; if (mst.q[0] !== core_req[c < 4 ? 1 : 0]) begin failed++; $display("FAIL lock_payload c%0d got %h want %h", c, mst.q[0], core_req[c < 4 ? 1 : 0]); end
      tests++; if (slv.q_ready !== (c < 3 ? 2'b00 : (c == 3 ? 2'b10 : 2'b01))) begin failed++; $display("FAIL lock_ready c%0d got %b", c, slv.q_ready); end
      tick();
      if (c == 3) slv.q_valid[1] = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    mst.q_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_core(0, 1'b1, 1'b1, c);
      tick();
    end
    set_core(0, 1'b1, 1'b1, 4);
    @(negedge clk);
    tests++; if (outstanding !== 3'd4) begin failed++; $display("FAIL full_outstanding got %0d want 4", outstanding); end
    tests++; if (mst.q_valid[0] !== 1'b0 || slv.q_ready !== 2'b00) begin failed++; $display("FAIL full_blocked got valid %b ready %b want 0 00", mst.q_valid[0], slv.q_ready); end
    tick();
    set_core(1, 1'b1, 1'b0, 5);
    @(negedge clk);
    tests++; if (slv.q_ready !== 2'b10) begin failed++; $display("FAIL full_nonwb got %b want 10", slv.q_ready); end
    tick();
    slv.q_valid[1] = 1'b0;
    slv.p_ready = 2'b11; mst.p_valid[0] = 1'b1; mst.p[0] = mk_rsp();
    @(negedge clk);
    tests++; if (slv.q_ready !== 2'b00 || slv.p_valid !== 2'b01) begin failed++; $display("FAIL full_pop_cycle got ready %b pvalid %b want 00 01", slv.q_ready, slv.p_valid); end
    tick();
    mst.p_valid[0] = 1'b0;
    @(negedge clk);
    tests++; if (slv.q_ready !== 2'b01 || outstanding !== 3'd3) begin failed++; $display("FAIL full_after_pop got ready %b out %0d want 01 3", slv.q_ready, outstanding); end
    tick();
    idle_inputs();
  endtask

  task automatic test_route();
    do_reset();
    mst.q_ready[0] = 1'b1;
    set_core(1, 1'b1, 1'b1, 1);
    tick();
    slv.q_valid[1] = 1'b0;
    set_core(0, 1'b1, 1'b1, 0);
    tick();
    idle_inputs();
    rsp = mk_rsp(); mst.p[0] = rsp; mst.p_valid[0] = 1'b1; slv.p_ready = 2'b01;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) slv.p_ready = 2'b11;
      if (c == 3) begin rsp = mk_rsp(); mst.p[0] = rsp; end
      @(negedge clk);
      tests++; if (mst.p_ready[0] !== (c >= 2)) begin failed++; $display("FAIL route_p_ready c%0d got %b want %b", c, mst.p_ready[0], c >= 2); end
      tests++; if (slv.p_valid !== (c < 3 ? 2'b10 : 2'b01)) begin failed++; $display("FAIL route_p_valid c%0d got %b", c, slv.p_valid); end
      tests++; if (slv.p[c < 3 ? 1 : 0] !== rsp) begin failed++; $display("FAIL route_data c%0d got %h want %h", c, slv.p[c < 3 ? 1 : 0], rsp); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    tests++; if (outstanding !== 3'd0) begin failed++; $display("FAIL route_drained got %0d want 0", outstanding); end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    mst.p_valid[0] = 1'b1; mst.p[0] = mk_rsp();
    @(negedge clk);
    tests++; if (mst.p_ready[0] !== 1'b1 || slv.p_valid !== 2'b00) begin failed++; $display("FAIL orphan_drop got ready %b pvalid %b want 1 00", mst.p_ready[0], slv.p_valid); end
    tick();
    mst.p_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (orphan !== 1'b1) begin failed++; $display("FAIL orphan_sticky c%0d got %b want 1", c, orphan); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    mst.q_ready[0] = 1'b1;
    set_core(1, 1'b1, 1'b1, 1);
    tick();
    slv.q_valid[1] = 1'b0;
    set_core(0, 1'b1, 1'b1, 0);
    tick();
    slv.q_valid[0] = 1'b0;
    mst.q_ready[0] = 1'b0;
    set_core(1, 1'b1, 1'b0, 3);
    tick();
    @(negedge clk);
    tests++; if (mst.q_valid[0] !== 1'b1 || outstanding !== 3'd2) begin failed++; $display("FAIL mid_locked got valid %b out %0d want 1 2", mst.q_valid[0], outstanding); end
    tick();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if ({mst.q_valid[0], slv.q_ready, slv.p_valid, mst.p_ready[0]} !== 6'b0) begin failed++; $display("FAIL mid_outputs got %b want 000000", {mst.q_valid[0], slv.q_ready, slv.p_valid, mst.p_ready[0]}); end
    tests++; if (outstanding !== 3'd0 || orphan !== 1'b0) begin failed++; $display("FAIL mid_state got out %0d orphan %b want 0 0", outstanding, orphan); end
    tick();
    rst_n = 1'b1;
    mst.q_ready[0] = 1'b1;
    set_core(0, 1'b1, 1'b0, 0);
    set_core(1, 1'b1, 1'b0, 1);
    @(negedge clk);
    tests++; if (slv.q_ready !== 2'b01) begin failed++; $display("FAIL mid_ptr got %b want 01", slv.q_ready); end
    tick();
    idle_inputs();
    mst.p_valid[0] = 1'b1; mst.p[0] = mk_rsp();
    @(negedge clk);
    tests++; if (mst.p_ready[0] !== 1'b1 || slv.p_valid !== 2'b00) begin failed++; $display("FAIL mid_late_rsp got ready %b pvalid %b want 1 00", mst.p_ready[0], slv.p_valid); end
    tick();
    mst.p_valid[0] = 1'b0;
    @(negedge clk);
    tests++; if (orphan !== 1'b1) begin failed++; $display("FAIL mid_orphan got %b want 1", orphan); end
    tick();
  endtask

  // Expected grant from the arbitration rules: locked core if any, else first eligible core from the pointer.
  task automatic model_grant();
    e_gv = 1'b0; e_g = 0;
    if (m_locked) begin
      e_g = m_lock; e_gv = slv.q_valid[m_lock];
    end else begin
      for (int k = 0; k < NR; k++) begin
        int idx = (m_ptr + k) % NR;
        if (!e_gv && slv.q_valid[idx] && (!slv.q_wb[idx] || rq.size() < MO)) begin
          e_gv = 1'b1; e_g = idx;
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_qr, exp_pv;
    bit         exp_pr, hs, do_pop;
    do_reset();
    m_ptr = 0; m_locked = 0; m_lock = 0; rq.delete(); m_orphan = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!slv.q_valid[i] && $urandom_range(0, 99) < 50) set_core(i, 1'b1, 1'($urandom), cyc);
      end
      mst.q_ready[0] = ($urandom_range(0, 99) < 60);
      mst.p_valid[0] = ($urandom_range(0, 99) < (rq.size() == 0 ? 5 : 40));
      rsp = mk_rsp(); mst.p[0] = rsp;
      slv.p_ready = 2'($urandom);
      @(negedge clk);
      model_grant();
      hs = e_gv && mst.q_ready[0];
      exp_qr = hs ? 2'(1 << e_g) : 2'b00;
      exp_pv = (mst.p_valid[0] && rq.size() > 0) ? 2'(1 << rq[0]) : 2'b00;
      exp_pr = mst.p_valid[0] && (rq.size() == 0 || slv.p_ready[rq[0]]);
      tests++; if (mst.q_valid[0] !== e_gv) begin failed++; $display("FAIL rnd_q_valid cyc%0d got %b want %b", cyc, mst.q_valid[0], e_gv); end
      tests++; if (slv.q_ready !== exp_qr) begin failed++; $display("FAIL rnd_q_ready cyc%0d got %b want %b", cyc, slv.q_ready, exp_qr); end
      if (e_gv) begin
        tests++; if (mst.q[0] !== core_req[e_g]) begin failed++; $display("FAIL rnd_q_payload cyc%0d got %h want %h", cyc, mst.q[0], core_req[e_g]); end
      end
      tests++; if (slv.p_valid !== exp_pv) begin failed++; $display("FAIL rnd_p_valid cyc%0d got %b want %b", cyc, slv.p_valid, exp_pv); end
      tests++; if (mst.p_ready[0] !== exp_pr) begin failed++; $display("FAIL rnd_p_ready cyc%0d got %b want %b", cyc, mst.p_ready[0], exp_pr); end
      if (exp_pv != 2'b00) begin
        tests++; if (slv.p[rq[0]] !== rsp) begin failed++; $display("FAIL rnd_p_data cyc%0d got %h want %h", cyc, slv.p[rq[0]], rsp); end
      end
      tests++; if (outstanding !== 3'(rq.size())) begin failed++; $display("FAIL rnd_outstanding cyc%0d got %0d want %0d", cyc, outstanding, rq.size()); end
      tests++; if (orphan !== m_orphan) begin failed++; $display("FAIL rnd_orphan cyc%0d got %b want %b", cyc, orphan, m_orphan); end
      do_pop = mst.p_valid[0] && rq.size() > 0 && slv.p_ready[rq[0]];
      if (mst.p_valid[0] && rq.size() == 0) m_orphan = 1'b1;
      if (do_pop) void'(rq.pop_front());
      if (hs) begin
        if (slv.q_wb[e_g]) rq.push_back(e_g);
        m_ptr = (e_g + 1) % NR;
        m_locked = 1'b0;
      end else if (e_gv) begin
        m_locked = 1'b1; m_lock = e_g;
      end
      tick();
      if (hs) slv.q_valid[e_g] = 1'b0;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_route();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
